// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID opcode, carries control through EX/MEM/WB and
// handles load-use stalls and flushes. Optional stall counter under CTRL_PERF_CNT_EN.
module pipelined_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [6:0]            id_opcode_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  illegal_o,
  output logic                  ex_valid_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic [1:0]            ex_alu_op_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic                  wb_mem_to_reg_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count_o
`endif
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam int unsigned LastMem = MEM_LAT - 1;

  typedef struct packed {
    logic                  valid;
    logic                  illegal;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic [1:0]            alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  ctrl_t dec, ex_d, ex_q, wb_q;
  ctrl_t mem_q [MEM_LAT];
  logic  use_rs1, use_rs2, hazard;

  function automatic logic load_hits(input ctrl_t w, input logic u1, input logic u2,
                                     input logic [REG_ADDR_W-1:0] rs1,
                                     input logic [REG_ADDR_W-1:0] rs2);
    return w.valid && w.mem_read && (w.rd != '0) &&
           ((u1 && (w.rd == rs1)) || (u2 && (w.rd == rs2)));
  endfunction

  always_comb begin
    dec       = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec.valid = 1'b1;
    dec.rd    = id_rd_i;
    case (id_opcode_i)
      OpR:    begin dec.alu_op = 2'b10; dec.reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpI:    begin
        dec.alu_op = 2'b11; dec.reg_write = 1'b1; dec.alu_src = 1'b1; use_rs1 = 1'b1;
      end
      OpLoad: begin
        dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src  = 1'b1; use_rs1 = 1'b1;
      end
      OpSt:   begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpBr:   begin dec.alu_op = 2'b01; dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpJal:  begin dec.reg_write = 1'b1; dec.jump = 1'b1; end
      OpJalr: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.jump = 1'b1; use_rs1 = 1'b1; end
      OpLui:  begin dec.alu_op = 2'b11; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
      default: begin dec.illegal = 1'b1; dec.rd = '0; end
    endcase
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  // The last MEM slot is not checked: its load data is ready by the time the consumer hits EX.
  always_comb begin
    hazard = load_hits(ex_q, use_rs1, use_rs2, id_rs1_i, id_rs2_i);
    for (int i = 0; i < int'(MEM_LAT) - 1; i++) begin
      hazard = hazard | load_hits(mem_q[i], use_rs1, use_rs2, id_rs1_i, id_rs2_i);
    end
    hazard = hazard & id_valid_i;
  end

  assign stall_o = hazard & ~flush_i;

  always_comb begin
    ex_d = dec;
    if (!id_valid_i || stall_o || flush_i) ex_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      wb_q <= '0;
      for (int i = 0; i < int'(MEM_LAT); i++) mem_q[i] <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q[0] <= ex_q;
      for (int i = 1; i < int'(MEM_LAT); i++) mem_q[i] <= mem_q[i-1];
      wb_q     <= mem_q[LastMem];
    end
  end

  assign illegal_o       = ex_q.illegal;
  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_branch_o     = ex_q.branch;
  assign ex_jump_o       = ex_q.jump;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign mem_valid_o     = mem_q[LastMem].valid;
  assign mem_read_o      = mem_q[LastMem].mem_read;
  assign mem_write_o     = mem_q[LastMem].mem_write;
  assign wb_valid_o      = wb_q.valid;
  assign wb_reg_write_o  = wb_q.reg_write;
  assign wb_mem_to_reg_o = wb_q.mem_to_reg;
  assign wb_rd_o         = wb_q.rd;

  logic unused_wb;
  assign unused_wb = ^{wb_q.illegal, wb_q.alu_src, wb_q.branch, wb_q.jump, wb_q.alu_op,
                       wb_q.mem_read, wb_q.mem_write};

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit; index 0 drives a MEM_LAT=1 instance,
// index 1 a MEM_LAT=3 instance. Expected MEM/WB words are queued at acceptance.
module tb_pipelined_control_unit;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpBad  = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       id_valid [2];
  logic       flush    [2];
  logic [6:0] id_op    [2];
  logic [4:0] rs1 [2], rs2 [2], rd [2];
  logic       stall [2], illegal [2], ex_valid [2], ex_alu_src [2], ex_branch [2], ex_jump [2];
  logic [1:0] ex_alu_op [2];
  logic       mem_valid [2], mem_read [2], mem_write [2];
  logic       wb_valid [2], wb_rw [2], wb_m2r [2];
  logic [4:0] wb_rd [2];
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] scnt [2];
`endif

  pipelined_control_unit #(.REG_ADDR_W(5), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid[0]), .id_opcode_i(id_op[0]),
    .id_rs1_i(rs1[0]), .id_rs2_i(rs2[0]), .id_rd_i(rd[0]), .flush_i(flush[0]),
    .stall_o(stall[0]), .illegal_o(illegal[0]), .ex_valid_o(ex_valid[0]),
    .ex_alu_src_o(ex_alu_src[0]), .ex_branch_o(ex_branch[0]), .ex_jump_o(ex_jump[0]),
    .ex_alu_op_o(ex_alu_op[0]), .mem_valid_o(mem_valid[0]), .mem_read_o(mem_read[0]),
    .mem_write_o(mem_write[0]), .wb_valid_o(wb_valid[0]), .wb_reg_write_o(wb_rw[0]),
    .wb_mem_to_reg_o(wb_m2r[0]), .wb_rd_o(wb_rd[0])
`ifdef CTRL_PERF_CNT_EN
    , .stall_count_o(scnt[0])
`endif
  );

  pipelined_control_unit #(.REG_ADDR_W(5), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid[1]), .id_opcode_i(id_op[1]),
    .id_rs1_i(rs1[1]), .id_rs2_i(rs2[1]), .id_rd_i(rd[1]), .flush_i(flush[1]),
    .stall_o(stall[1]), .illegal_o(illegal[1]), .ex_valid_o(ex_valid[1]),
    .ex_alu_src_o(ex_alu_src[1]), .ex_branch_o(ex_branch[1]), .ex_jump_o(ex_jump[1]),
    .ex_alu_op_o(ex_alu_op[1]), .mem_valid_o(mem_valid[1]), .mem_read_o(mem_read[1]),
    .mem_write_o(mem_write[1]), .wb_valid_o(wb_valid[1]), .wb_reg_write_o(wb_rw[1]),
    .wb_mem_to_reg_o(wb_m2r[1]), .wb_rd_o(wb_rd[1])
`ifdef CTRL_PERF_CNT_EN
    , .stall_count_o(scnt[1])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] memq0 [$], memq1 [$];
  logic [6:0] wbq0 [$], wbq1 [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {alu_op[1:0], alu_src, branch, jump, mem_read, mem_write, reg_write, mem_to_reg}
  function automatic logic [8:0] exp_ctrl(input logic [6:0] op);
    case (op)
      OpR:     return 9'b10_000_00_10;
      OpI:     return 9'b11_100_00_10;
      OpLoad:  return 9'b00_100_10_11;
      OpSt:    return 9'b00_100_01_00;
      OpBr:    return 9'b01_010_00_00;
      OpJal:   return 9'b00_001_00_10;
      OpJalr:  return 9'b00_101_00_10;
      OpLui:   return 9'b11_100_00_10;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OpR, OpI, OpLoad, OpSt, OpBr, OpJal, OpJalr, OpLui};
  endfunction

  task automatic drv(input int d, input logic v, input logic [6:0] op, input logic [4:0] a,
                     input logic [4:0] b, input logic [4:0] r, input logic f);
    id_valid[d] = v; id_op[d] = op; rs1[d] = a; rs2[d] = b; rd[d] = r; flush[d] = f;
  endtask

  task automatic idle(input int d, input int n);
    drv(d, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input logic [6:0] op, input logic [4:0] r);
    logic [8:0] c;
    logic [6:0] w;
    c = exp_ctrl(op);
    w = {c[1] && (r != 5'd0), c[0], is_legal(op) ? r : 5'd0};
    if (d == 0) begin memq0.push_back(c[3:2]); wbq0.push_back(w); end
    else        begin memq1.push_back(c[3:2]); wbq1.push_back(w); end
  endtask

  // Enter at a negedge; hold the instruction through n_stall stall cycles until accepted.
  task automatic issue(input int d, input logic [6:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] r, input int n_stall);
    logic [8:0] c;
    c = exp_ctrl(op);
    drv(d, 1'b1, op, a, b, r, 1'b0);
    for (int k = 0; k <= n_stall; k++) begin
      #1;
      check_eq($sformatf("stall d%0d op%b k%0d", d, op, k), 32'(stall[d]), 32'(k < n_stall));
      if (k > 0) check_eq($sformatf("ex_bubble d%0d k%0d", d, k), 32'(ex_valid[d]), 32'd0);
      @(negedge clk);
    end
    push(d, op, r);
    check_eq($sformatf("ex_valid d%0d op%b", d, op), 32'(ex_valid[d]), 32'd1);
    check_eq($sformatf("ex_ctrl d%0d op%b", d, op),
             32'({ex_alu_op[d], ex_alu_src[d], ex_branch[d], ex_jump[d]}), 32'(c[8:4]));
    check_eq($sformatf("illegal d%0d op%b", d, op), 32'(illegal[d]), 32'(!is_legal(op)));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid[0]) begin
        if (memq0.size() == 0) check_eq("mem0_extra", 32'(mem_valid[0]), 32'd0);
        else check_eq("mem0_ctrl", 32'({mem_read[0], mem_write[0]}), 32'(memq0.pop_front()));
      end
      if (mem_valid[1]) begin
        if (memq1.size() == 0) check_eq("mem1_extra", 32'(mem_valid[1]), 32'd0);
        else check_eq("mem1_ctrl", 32'({mem_read[1], mem_write[1]}), 32'(memq1.pop_front()));
      end
      if (wb_valid[0]) begin
        if (wbq0.size() == 0) check_eq("wb0_extra", 32'(wb_valid[0]), 32'd0);
        else check_eq("wb0_word", 32'({wb_rw[0], wb_m2r[0], wb_rd[0]}), 32'(wbq0.pop_front()));
      end
      if (wb_valid[1]) begin
        if (wbq1.size() == 0) check_eq("wb1_extra", 32'(wb_valid[1]), 32'd0);
        else check_eq("wb1_word", 32'({wb_rw[1], wb_m2r[1], wb_rd[1]}), 32'(wbq1.pop_front()));
      end
    end
  end

  initial begin
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] before;
`endif
    for (int d = 0; d < 2; d++) drv(d, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_stall d%0d", d), 32'(stall[d]), 32'd0);
      check_eq($sformatf("rst_ex d%0d", d),
               32'({ex_valid[d], illegal[d], ex_alu_op[d], ex_alu_src[d], ex_branch[d],
                    ex_jump[d]}), 32'd0);
      check_eq($sformatf("rst_memwb d%0d", d),
               32'({mem_valid[d], mem_read[d], mem_write[d], wb_valid[d], wb_rw[d], wb_m2r[d],
                    wb_rd[d]}), 32'd0);
`ifdef CTRL_PERF_CNT_EN
      check_eq($sformatf("rst_scnt d%0d", d), scnt[d], 32'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);

    // MEM_LAT=1: R-type latency to MEM and WB
    issue(0, OpR, 5'd1, 5'd2, 5'd3, 0);
    idle(0, 1);
    check_eq("lat_mem1", 32'(mem_valid[0]), 32'd1);
    idle(0, 1);
    check_eq("lat_wb1", 32'({wb_valid[0], wb_rw[0], wb_rd[0]}), 32'({1'b1, 1'b1, 5'd3}));

    // Load-use on rs1, store rs2, I rs2 (ignored), LUI (ignored), JALR rs1
    issue(0, OpLoad, 5'd1, 5'd0, 5'd5, 0);
    issue(0, OpR,    5'd5, 5'd6, 5'd8, 1);
    issue(0, OpLoad, 5'd1, 5'd0, 5'd4, 0);
    issue(0, OpSt,   5'd1, 5'd4, 5'd0, 1);
    issue(0, OpLoad, 5'd1, 5'd0, 5'd4, 0);
    issue(0, OpI,    5'd1, 5'd4, 5'd9, 0);
    issue(0, OpLoad, 5'd1, 5'd0, 5'd4, 0);
    issue(0, OpLui,  5'd4, 5'd4, 5'd10, 0);
    issue(0, OpLoad, 5'd1, 5'd0, 5'd4, 0);
    issue(0, OpJalr, 5'd4, 5'd0, 5'd1, 1);
    // rd=0 load never hazards and never writes back
    issue(0, OpLoad, 5'd1, 5'd0, 5'd0, 0);
    issue(0, OpR,    5'd0, 5'd0, 5'd11, 0);
    issue(0, OpJal,  5'd0, 5'd0, 5'd1, 0);
    issue(0, OpBr,   5'd1, 5'd2, 5'd0, 0);

    // Flush overrides a live load-use hazard
    issue(0, OpLoad, 5'd1, 5'd0, 5'd7, 0);
`ifdef CTRL_PERF_CNT_EN
    before = scnt[0];
`endif
    drv(0, 1'b1, OpR, 5'd7, 5'd0, 5'd13, 1'b1);
    #1;
    check_eq("flush_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    check_eq("flush_ex_bubble", 32'(ex_valid[0]), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check_eq("flush_scnt", scnt[0], before);
`endif

    // Illegal opcode reaches EX, then a bubble clears it
    issue(0, OpBad, 5'd1, 5'd2, 5'd3, 0);
    idle(0, 1);
    check_eq("illegal_clear", 32'(illegal[0]), 32'd0);
    idle(0, 5);

    // MEM_LAT=3: back-to-back dependency stalls 3, one gap stalls 2
    issue(1, OpLoad, 5'd1, 5'd0, 5'd5, 0);
    issue(1, OpR,    5'd5, 5'd0, 5'd12, 3);
`ifdef CTRL_PERF_CNT_EN
    check_eq("scnt3_a", scnt[1], 32'd3);
`endif
    issue(1, OpLoad, 5'd1, 5'd0, 5'd6, 0);
    idle(1, 1);
    issue(1, OpR,    5'd6, 5'd0, 5'd14, 2);
`ifdef CTRL_PERF_CNT_EN
    check_eq("scnt3_b", scnt[1], 32'd5);
`endif
    idle(1, 6);
    // EX to mem_* takes MEM_LAT cycles
    issue(1, OpSt, 5'd2, 5'd3, 5'd0, 0);
    idle(1, 2);
    check_eq("lat3_mem_early", 32'(mem_valid[1]), 32'd0);
    idle(1, 1);
    check_eq("lat3_mem", 32'({mem_valid[1], mem_write[1]}), 32'b11);
    idle(1, 6);
    check_eq("sb_drained", 32'(memq0.size() + memq1.size() + wbq0.size() + wbq1.size()), 32'd0);

    // Reset asserted mid-stall drops stall at once
    drv(1, 1'b1, OpLoad, 5'd1, 5'd0, 5'd9, 1'b0);
    @(negedge clk);
    drv(1, 1'b1, OpR, 5'd9, 5'd0, 5'd15, 1'b0);
    #1;
    check_eq("pre_rst_stall", 32'(stall[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stall", 32'(stall[1]), 32'd0);
    check_eq("rst_mid_ex", 32'(ex_valid[1]), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check_eq("rst_mid_scnt", scnt[1], 32'd0);
`endif
    idle(1, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
